// File: rtl/bb_arb_rr_if.sv
// ---------------------------------------------------------------------------
// bb_arb_rr_if
// Bundle of every bus signal around the two-master round-robin arbiter that
// fronts a single BB slave. Signal names keep the arbiter's own _i/_o sense
// so the wiring reads the same from either side.
//
//   mN_addr_i / mN_din_i / mN_en_i / mN_we_i / mN_lock_i : master N request
//   mN_ack_o   : master N access accepted this cycle
//   mN_rvalid_o: master N read data valid (one cycle after its read)
//   mN_dout_o  : master N read data
//   bb_addr_o / bb_din_o / bb_en_o / bb_we_o : access issued to the BB slave
//   bb_dout_i  : BB slave read data, valid one cycle after a read
//
// Modports:
//   slave  - the arbiter (slave of the requesting masters)
//   master - the environment: requesting masters plus the BB slave model
// ---------------------------------------------------------------------------
interface bb_arb_rr_if #(
    parameter int DW = 32,
    parameter int AW = 32
) ();

    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_din_i;
    logic          m0_en_i;
    logic          m0_we_i;
    logic          m0_lock_i;
    logic          m0_ack_o;
    logic          m0_rvalid_o;
    logic [DW-1:0] m0_dout_o;

    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_din_i;
    logic          m1_en_i;
    logic          m1_we_i;
    logic          m1_lock_i;
    logic          m1_ack_o;
    logic          m1_rvalid_o;
    logic [DW-1:0] m1_dout_o;

    logic [AW-1:0] bb_addr_o;
    logic [DW-1:0] bb_din_o;
    logic          bb_en_o;
    logic          bb_we_o;
    logic [DW-1:0] bb_dout_i;

    modport slave (
        input  m0_addr_i, m0_din_i, m0_en_i, m0_we_i, m0_lock_i,
        output m0_ack_o, m0_rvalid_o, m0_dout_o,
        input  m1_addr_i, m1_din_i, m1_en_i, m1_we_i, m1_lock_i,
        output m1_ack_o, m1_rvalid_o, m1_dout_o,
        output bb_addr_o, bb_din_o, bb_en_o, bb_we_o,
        input  bb_dout_i
    );

    modport master (
        output m0_addr_i, m0_din_i, m0_en_i, m0_we_i, m0_lock_i,
        input  m0_ack_o, m0_rvalid_o, m0_dout_o,
        output m1_addr_i, m1_din_i, m1_en_i, m1_we_i, m1_lock_i,
        input  m1_ack_o, m1_rvalid_o, m1_dout_o,
        input  bb_addr_o, bb_din_o, bb_en_o, bb_we_o,
        output bb_dout_i
    );

endinterface

// File: rtl/bb_arb_rr.sv
// ---------------------------------------------------------------------------
// bb_arb_rr
// Two-master arbiter in front of a single-cycle BB slave.
//
// Arbitration is combinational in the request cycle, so a granted access
// reaches the slave with no added latency. Priority order:
//   1. lock: the master granted last cycle with lock high keeps the grant
//      while it keeps requesting,
//   2. round robin when both request: the master not in last_gnt wins,
//   3. otherwise the single requester.
// Read data returns one cycle after issue; rd_pend/rd_id steer the rvalid
// to the right master, which lets a new grant overlap the return.
//
// Ports:
//   bb_clk_i  - clock
//   bb_rst_i  - synchronous active-high reset
//   bb_if     - request/response bundle for both masters and the BB slave
//
// Parameters:
//   DW - data width (32, 16 or 8); AW - byte address width
// ---------------------------------------------------------------------------
module bb_arb_rr #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic        bb_clk_i,
    input  logic        bb_rst_i,
    bb_arb_rr_if.slave  bb_if
);

    // Stored state
    logic          last_gnt_q, last_gnt_d;
    logic          lock_vld_q, lock_vld_d;
    logic          lock_id_q,  lock_id_d;
    logic          rd_pend_q,  rd_pend_d;
    logic          rd_id_q,    rd_id_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [DW-1:0] din_q,      din_d;

    // Grant decision and the selected master's request fields
    logic          lock_hit_s;
    logic          gnt_vld_s;
    logic          gnt_id_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_din_s;
    logic          sel_we_s;
    logic          sel_lock_s;

    // Arbitration: reset blocks every grant; lock beats round robin
    always_comb begin
        lock_hit_s = 1'b0;
        gnt_vld_s  = 1'b0;
        gnt_id_s   = 1'b0;
        if (bb_rst_i) begin
            lock_hit_s = 1'b0;
            gnt_vld_s  = 1'b0;
        end else begin
            // Lock still owned only while the owner keeps requesting
            lock_hit_s = lock_vld_q & (lock_id_q ? bb_if.m1_en_i : bb_if.m0_en_i);
            if (lock_hit_s) begin
                gnt_vld_s = 1'b1;
                gnt_id_s  = lock_id_q;
            end else if (bb_if.m0_en_i && bb_if.m1_en_i) begin
                gnt_vld_s = 1'b1;
                gnt_id_s  = ~last_gnt_q;
            end else if (bb_if.m0_en_i) begin
                gnt_vld_s = 1'b1;
                gnt_id_s  = 1'b0;
            end else if (bb_if.m1_en_i) begin
                gnt_vld_s = 1'b1;
                gnt_id_s  = 1'b1;
            end else begin
                gnt_vld_s = 1'b0;
                gnt_id_s  = 1'b0;
            end
        end
    end

    // Request mux: pick the fields of the master named by gnt_id_s
    always_comb begin
        sel_addr_s = bb_if.m0_addr_i;
        sel_din_s  = bb_if.m0_din_i;
        sel_we_s   = bb_if.m0_we_i;
        sel_lock_s = bb_if.m0_lock_i;
        if (gnt_id_s) begin
            sel_addr_s = bb_if.m1_addr_i;
            sel_din_s  = bb_if.m1_din_i;
            sel_we_s   = bb_if.m1_we_i;
            sel_lock_s = bb_if.m1_lock_i;
        end else begin
            sel_addr_s = bb_if.m0_addr_i;
            sel_din_s  = bb_if.m0_din_i;
            sel_we_s   = bb_if.m0_we_i;
            sel_lock_s = bb_if.m0_lock_i;
        end
    end

    // Next state: a grant records winner, lock, read tracking and bus values;
    // an idle cycle drops lock and pending read but holds address/data
    always_comb begin
        last_gnt_d = last_gnt_q;
        lock_vld_d = 1'b0;
        lock_id_d  = lock_id_q;
        rd_pend_d  = 1'b0;
        rd_id_d    = rd_id_q;
        addr_d     = addr_q;
        din_d      = din_q;
        if (gnt_vld_s) begin
            last_gnt_d = gnt_id_s;
            lock_vld_d = sel_lock_s;
            lock_id_d  = gnt_id_s;
            rd_pend_d  = ~sel_we_s;
            rd_id_d    = gnt_id_s;
            addr_d     = sel_addr_s;
            din_d      = sel_din_s;
        end else begin
            lock_vld_d = 1'b0;
            rd_pend_d  = 1'b0;
        end
    end

    // State registers with synchronous reset; last_gnt=1 lets m0 win first
    always_ff @(posedge bb_clk_i) begin
        if (bb_rst_i) begin
            last_gnt_q <= 1'b1;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_id_q    <= 1'b0;
            addr_q     <= {AW{1'b0}};
            din_q      <= {DW{1'b0}};
        end else begin
            last_gnt_q <= last_gnt_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            rd_pend_q  <= rd_pend_d;
            rd_id_q    <= rd_id_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    // Slave side: the granted access passes straight through; with no grant
    // the last address/data stay on the bus so the slave sees a stable value
    assign bb_if.bb_en_o   = gnt_vld_s;
    assign bb_if.bb_we_o   = gnt_vld_s & sel_we_s;
    assign bb_if.bb_addr_o = gnt_vld_s ? sel_addr_s : addr_q;
    assign bb_if.bb_din_o  = gnt_vld_s ? sel_din_s  : din_q;

    // Master side acks follow the grant of this cycle
    assign bb_if.m0_ack_o = gnt_vld_s & ~gnt_id_s;
    assign bb_if.m1_ack_o = gnt_vld_s &  gnt_id_s;

    // Read return: a reset arriving while a read is pending suppresses it
    assign bb_if.m0_rvalid_o = rd_pend_q & ~bb_rst_i & ~rd_id_q;
    assign bb_if.m1_rvalid_o = rd_pend_q & ~bb_rst_i &  rd_id_q;

    // Slave read data is shared; each master qualifies it with its rvalid
    assign bb_if.m0_dout_o = bb_if.bb_dout_i;
    assign bb_if.m1_dout_o = bb_if.bb_dout_i;

endmodule

// File: tb/tb_bb_arb_rr.sv
// Self-checking bench for bb_arb_rr: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_bb_arb_rr;

    logic clk;
    logic rst;

    bb_arb_rr_if #(.DW(32), .AW(32)) bus ();

    bb_arb_rr #(.DW(32), .AW(32)) dut (
        .bb_clk_i (clk),
        .bb_rst_i (rst),
        .bb_if    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Current cycle stimulus (mirror of what was driven)
    logic        cur_rst;
    logic        cur_en   [2];
    logic        cur_we   [2];
    logic        cur_lock [2];
    logic [31:0] cur_addr [2];
    logic [31:0] cur_din  [2];
    logic [31:0] cur_dout;

    // Model state: winner of last grant, lock owner (-1 none), pending read
    // owner (-1 none), bus values last driven
    int          m_last    = 1;
    int          m_lock    = -1;
    int          m_rd      = -1;
    logic [31:0] m_addr    = 32'h0;
    logic [31:0] m_din     = 32'h0;
    int          exp_win   = -1;

    task automatic model_predict();
        exp_win = -1;
        if (!cur_rst) begin
            if (m_lock >= 0 && cur_en[m_lock]) exp_win = m_lock;
            else if (cur_en[0] && cur_en[1])  exp_win = 1 - m_last;
            else if (cur_en[0])               exp_win = 0;
            else if (cur_en[1])               exp_win = 1;
        end
    endtask

    task automatic model_update();
        if (cur_rst) begin
            m_last = 1; m_lock = -1; m_rd = -1; m_addr = 32'h0; m_din = 32'h0;
        end else if (exp_win >= 0) begin
            m_last = exp_win;
            m_lock = cur_lock[exp_win] ? exp_win : -1;
            m_rd   = cur_we[exp_win] ? -1 : exp_win;
            m_addr = cur_addr[exp_win];
            m_din  = cur_din[exp_win];
        end else begin
            m_lock = -1; m_rd = -1;
        end
    endtask

    // Drive one cycle of inputs just after the edge, then move to mid-cycle
    task automatic drive(input logic r,
                         input logic e0, input logic w0, input logic l0,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic e1, input logic w1, input logic l1,
                         input logic [31:0] a1, input logic [31:0] d1);
        rst = r;
        bus.m0_en_i = e0; bus.m0_we_i = w0; bus.m0_lock_i = l0;
        bus.m0_addr_i = a0; bus.m0_din_i = d0;
        bus.m1_en_i = e1; bus.m1_we_i = w1; bus.m1_lock_i = l1;
        bus.m1_addr_i = a1; bus.m1_din_i = d1;
        cur_dout = $urandom;
        bus.bb_dout_i = cur_dout;
        cur_rst = r;
        cur_en[0] = e0; cur_we[0] = w0; cur_lock[0] = l0; cur_addr[0] = a0; cur_din[0] = d0;
        cur_en[1] = e1; cur_we[1] = w1; cur_lock[1] = l1; cur_addr[1] = a1; cur_din[1] = d1;
        model_predict();
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1, 32'h3, 32'h4);
            n_total++;
            if (bus.bb_en_o !== 1'b0 || bus.m0_ack_o !== 1'b0 || bus.m1_ack_o !== 1'b0)
                $display("FAIL reset_en_ack: en=%b ack0=%b ack1=%b expected 0 0 0",
                         bus.bb_en_o, bus.m0_ack_o, bus.m1_ack_o);
            else n_pass++;
            n_total++;
            if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0)
                $display("FAIL reset_rvalid: rv0=%b rv1=%b expected 0 0",
                         bus.m0_rvalid_o, bus.m1_rvalid_o);
            else n_pass++;
            tick();
        end
        idle();
        n_total++;
        if (bus.bb_en_o !== 1'b0 || bus.bb_we_o !== 1'b0 ||
            bus.bb_addr_o !== 32'h0 || bus.bb_din_o !== 32'h0)
            $display("FAIL reset_bus: en=%b we=%b addr=%h din=%h expected 0 0 0 0",
                     bus.bb_en_o, bus.bb_we_o, bus.bb_addr_o, bus.bb_din_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_single_read();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_total++;
        if (bus.bb_en_o !== 1'b1 || bus.bb_addr_o !== 32'h100 || bus.bb_we_o !== 1'b0)
            $display("FAIL read_issue: en=%b addr=%h we=%b expected 1 100 0",
                     bus.bb_en_o, bus.bb_addr_o, bus.bb_we_o);
        else n_pass++;
        n_total++;
        if (bus.m0_ack_o !== 1'b1 || bus.m1_ack_o !== 1'b0)
            $display("FAIL read_ack: ack0=%b ack1=%b expected 1 0", bus.m0_ack_o, bus.m1_ack_o);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.m0_rvalid_o !== 1'b1 || bus.m1_rvalid_o !== 1'b0 || bus.m0_dout_o !== cur_dout)
            $display("FAIL read_return: rv0=%b rv1=%b dout0=%h expected 1 0 %h",
                     bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m0_dout_o, cur_dout);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.m0_rvalid_o !== 1'b0)
            $display("FAIL read_one_shot: rv0=%b expected 0", bus.m0_rvalid_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_round_robin();
        logic [31:0] a0, a1;
        int          want;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            a0 = $urandom; a1 = $urandom;
            want = k % 2;
            drive(1'b0, 1'b1, 1'b1, 1'b0, a0, 32'h11, 1'b1, 1'b1, 1'b0, a1, 32'h22);
            n_total++;
            if (bus.m0_ack_o !== (want == 0) || bus.m1_ack_o !== (want == 1))
                $display("FAIL rr_grant[%0d]: ack0=%b ack1=%b expected m%0d", k,
                         bus.m0_ack_o, bus.m1_ack_o, want);
            else n_pass++;
            n_total++;
            if (bus.bb_addr_o !== ((want == 0) ? a0 : a1))
                $display("FAIL rr_addr[%0d]: addr=%h expected %h", k, bus.bb_addr_o,
                         (want == 0) ? a0 : a1);
            else n_pass++;
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_lock();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h5, 1'b1, 1'b1, 1'b1, 32'h60 + k, 32'h6);
            n_total++;
            if (bus.m1_ack_o !== 1'b1 || bus.m0_ack_o !== 1'b0)
                $display("FAIL lock_hold[%0d]: ack0=%b ack1=%b expected 0 1", k,
                         bus.m0_ack_o, bus.m1_ack_o);
            else n_pass++;
            n_total++;
            if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0)
                $display("FAIL lock_rvalid[%0d]: rv0=%b rv1=%b expected 0 0", k,
                         bus.m0_rvalid_o, bus.m1_rvalid_o);
            else n_pass++;
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_total++;
        if (bus.m0_ack_o !== 1'b1 || bus.m1_ack_o !== 1'b0)
            $display("FAIL lock_release: ack0=%b ack1=%b expected 1 0", bus.m0_ack_o, bus.m1_ack_o);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0)
            $display("FAIL lock_write_rvalid: rv0=%b rv1=%b expected 0 0",
                     bus.m0_rvalid_o, bus.m1_rvalid_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_total++;
        if (bus.m0_ack_o !== 1'b1 || bus.bb_addr_o !== 32'h10)
            $display("FAIL b2b_issue0: ack0=%b addr=%h expected 1 10", bus.m0_ack_o, bus.bb_addr_o);
        else n_pass++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        n_total++;
        if (bus.m1_ack_o !== 1'b1 || bus.bb_addr_o !== 32'h20 || bus.bb_en_o !== 1'b1)
            $display("FAIL b2b_issue1: ack1=%b addr=%h en=%b expected 1 20 1",
                     bus.m1_ack_o, bus.bb_addr_o, bus.bb_en_o);
        else n_pass++;
        n_total++;
        if (bus.m0_rvalid_o !== 1'b1 || bus.m1_rvalid_o !== 1'b0 || bus.m0_dout_o !== cur_dout)
            $display("FAIL b2b_ret0: rv0=%b rv1=%b dout0=%h expected 1 0 %h",
                     bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m0_dout_o, cur_dout);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.m1_rvalid_o !== 1'b1 || bus.m0_rvalid_o !== 1'b0 || bus.m1_dout_o !== cur_dout)
            $display("FAIL b2b_ret1: rv0=%b rv1=%b dout1=%h expected 0 1 %h",
                     bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m1_dout_o, cur_dout);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h31, 32'h0, 1'b1, 1'b0, 1'b0, 32'h32, 32'h0);
        n_total++;
        if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0)
            $display("FAIL rst_mid_rvalid: rv0=%b rv1=%b expected 0 0",
                     bus.m0_rvalid_o, bus.m1_rvalid_o);
        else n_pass++;
        n_total++;
        if (bus.bb_en_o !== 1'b0 || bus.m0_ack_o !== 1'b0 || bus.m1_ack_o !== 1'b0)
            $display("FAIL rst_mid_ack: en=%b ack0=%b ack1=%b expected 0 0 0",
                     bus.bb_en_o, bus.m0_ack_o, bus.m1_ack_o);
        else n_pass++;
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h33, 32'h0, 1'b1, 1'b1, 1'b0, 32'h34, 32'h0);
        n_total++;
        if (bus.m0_ack_o !== 1'b1 || bus.m1_ack_o !== 1'b0 || bus.m0_rvalid_o !== 1'b0)
            $display("FAIL rst_mid_regrant: ack0=%b ack1=%b rv0=%b expected 1 0 0",
                     bus.m0_ack_o, bus.m1_ack_o, bus.m0_rvalid_o);
        else n_pass++;
        tick();
        idle();
        tick();
    endtask

    task automatic test_idle_hold();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 1'b0, 1'b0, 1'b0, 32'h99, 32'h1);
            n_total++;
            if (bus.bb_en_o !== 1'b0 || bus.bb_we_o !== 1'b0 ||
                bus.bb_addr_o !== 32'h44 || bus.bb_din_o !== 32'hA5A5A5A5)
                $display("FAIL idle_hold[%0d]: en=%b we=%b addr=%h din=%h expected 0 0 44 a5a5a5a5",
                         k, bus.bb_en_o, bus.bb_we_o, bus.bb_addr_o, bus.bb_din_o);
            else n_pass++;
            n_total++;
            if (bus.m0_ack_o !== 1'b0 || bus.m1_ack_o !== 1'b0 ||
                bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0)
                $display("FAIL idle_quiet[%0d]: ack0=%b ack1=%b rv0=%b rv1=%b expected 0 0 0 0", k,
                         bus.m0_ack_o, bus.m1_ack_o, bus.m0_rvalid_o, bus.m1_rvalid_o);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        logic        e_en, e_we, e_rv0, e_rv1;
        logic [31:0] e_addr, e_din;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(31, 0) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(9, 0) < 7) ? 1'b1 : 1'b0, 1'($urandom),
                  ($urandom_range(9, 0) < 4) ? 1'b1 : 1'b0, $urandom, $urandom,
                  ($urandom_range(9, 0) < 7) ? 1'b1 : 1'b0, 1'($urandom),
                  ($urandom_range(9, 0) < 4) ? 1'b1 : 1'b0, $urandom, $urandom);
            e_en   = (exp_win >= 0);
            e_we   = e_en ? cur_we[exp_win] : 1'b0;
            e_addr = e_en ? cur_addr[exp_win] : m_addr;
            e_din  = e_en ? cur_din[exp_win] : m_din;
            e_rv0  = !cur_rst && (m_rd == 0);
            e_rv1  = !cur_rst && (m_rd == 1);
            n_total++;
            if (bus.bb_en_o !== e_en || bus.m0_ack_o !== (exp_win == 0) ||
                bus.m1_ack_o !== (exp_win == 1))
                $display("FAIL rand_grant[%0d]: en=%b ack0=%b ack1=%b expected winner %0d", c,
                         bus.bb_en_o, bus.m0_ack_o, bus.m1_ack_o, exp_win);
            else n_pass++;
            n_total++;
            if (bus.bb_we_o !== e_we || bus.bb_addr_o !== e_addr || bus.bb_din_o !== e_din)
                $display("FAIL rand_bus[%0d]: we=%b addr=%h din=%h expected %b %h %h", c,
                         bus.bb_we_o, bus.bb_addr_o, bus.bb_din_o, e_we, e_addr, e_din);
            else n_pass++;
            n_total++;
            if (bus.m0_rvalid_o !== e_rv0 || bus.m1_rvalid_o !== e_rv1)
                $display("FAIL rand_rvalid[%0d]: rv0=%b rv1=%b expected %b %b", c,
                         bus.m0_rvalid_o, bus.m1_rvalid_o, e_rv0, e_rv1);
            else n_pass++;
            if (e_rv0 || e_rv1) begin
                n_total++;
                if ((e_rv0 && bus.m0_dout_o !== cur_dout) || (e_rv1 && bus.m1_dout_o !== cur_dout))
                    $display("FAIL rand_dout[%0d]: dout0=%h dout1=%h expected %h", c,
                             bus.m0_dout_o, bus.m1_dout_o, cur_dout);
                else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.m0_en_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_lock_i = 1'b0;
        bus.m0_addr_i = 32'h0; bus.m0_din_i = 32'h0;
        bus.m1_en_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_lock_i = 1'b0;
        bus.m1_addr_i = 32'h0; bus.m1_din_i = 32'h0;
        bus.bb_dout_i = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_back_to_back();
        test_reset_mid_read();
        test_idle_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
